// File: rtl/divsub_sign_13_6.sv
// Sequential signed divider (restoring, one quotient bit per clock).
//
// Computes dividend = quotient * divisor + remainder with the quotient truncated
// toward zero and saturated to the Q_WIDTH signed range, and the remainder taking
// the sign of the dividend.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request, sampled only while busy is low
//   dividend     N_WIDTH signed dividend, captured with start
//   divisor      D_WIDTH signed divisor, captured with start
//   busy         high from the accepting edge until the result edge
//   done         one-cycle pulse, result valid
//   quotient     Q_WIDTH signed quotient (saturated)
//   remainder    D_WIDTH signed remainder
//   div_by_zero  divisor was zero (held with the result)
//   overflow     true quotient outside the Q_WIDTH signed range (held with the result)
module divsub_sign_13_6 #(
  parameter int unsigned N_WIDTH = 13,
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned Q_WIDTH = N_WIDTH - D_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [Q_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  // Magnitudes carry one extra bit so the most negative operand is representable.
  localparam int unsigned MW = N_WIDTH + 1;
  localparam int unsigned PW = D_WIDTH + 1;
  localparam int unsigned CW = $clog2(N_WIDTH);

  localparam logic [N_WIDTH-1:0] QMaxMag = N_WIDTH'(2 ** (Q_WIDTH - 1) - 1);
  localparam logic [N_WIDTH-1:0] QMinMag = N_WIDTH'(2 ** (Q_WIDTH - 1));
  localparam logic [Q_WIDTH-1:0] QMaxVal = {1'b0, {(Q_WIDTH - 1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] QMinVal = {1'b1, {(Q_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e             state;
  logic [MW-1:0]      n_mag;    // dividend magnitude, shifted out MSB first
  logic [PW-1:0]      d_mag;
  logic [PW-1:0]      part_rem;
  logic [N_WIDTH-1:0] q_mag;
  logic [CW-1:0]      cnt;
  logic               q_neg;
  logic               r_neg;
  logic               dz_flag;

  // Operand magnitudes at capture time.
  logic [MW-1:0] n_ext;
  logic [MW-1:0] n_abs;
  logic [PW-1:0] d_ext;
  logic [PW-1:0] d_abs;

  always_comb begin
    n_ext = {dividend[N_WIDTH-1], dividend};
    d_ext = {divisor[D_WIDTH-1], divisor};
    n_abs = dividend[N_WIDTH-1] ? -n_ext : n_ext;
    d_abs = divisor[D_WIDTH-1] ? -d_ext : d_ext;
  end

  // One restoring step. part_rem < |divisor| <= 2^(D_WIDTH-1), so dropping its
  // top bit on the shift never loses information.
  logic [PW-1:0] shifted;
  logic          q_bit;
  logic [PW-1:0] rem_step;

  always_comb begin
    shifted  = {part_rem[PW-2:0], n_mag[N_WIDTH-1]};
    q_bit    = (shifted >= d_mag);
    rem_step = q_bit ? (shifted - d_mag) : shifted;
  end

  // Sign restoration and saturation of the final result.
  logic [Q_WIDTH-1:0] q_trunc;
  logic [D_WIDTH-1:0] r_trunc;
  logic               ovf_fin;
  logic [Q_WIDTH-1:0] q_fin;
  logic [D_WIDTH-1:0] r_fin;

  always_comb begin
    q_trunc = q_mag[Q_WIDTH-1:0];
    r_trunc = part_rem[D_WIDTH-1:0];
    ovf_fin = 1'b0;
    q_fin   = q_neg ? -q_trunc : q_trunc;
    r_fin   = r_neg ? -r_trunc : r_trunc;
    if (dz_flag) begin
      q_fin = r_neg ? QMinVal : QMaxVal;
      r_fin = '0;
    end else begin
      // A negative result may reach one magnitude further than a positive one.
      ovf_fin = q_neg ? (q_mag > QMinMag) : (q_mag > QMaxMag);
      if (ovf_fin) begin
        q_fin = q_neg ? QMinVal : QMaxVal;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      n_mag       <= '0;
      d_mag       <= '0;
      part_rem    <= '0;
      q_mag       <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz_flag     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            n_mag    <= n_abs;
            d_mag    <= d_abs;
            q_neg    <= dividend[N_WIDTH-1] ^ divisor[D_WIDTH-1];
            r_neg    <= dividend[N_WIDTH-1];
            part_rem <= '0;
            q_mag    <= '0;
            cnt      <= CW'(N_WIDTH - 1);
            busy     <= 1'b1;
            dz_flag  <= (divisor == '0);
            state    <= (divisor == '0) ? StFinish : StCalc;
          end
        end
        StCalc: begin
          part_rem <= rem_step;
          q_mag    <= {q_mag[N_WIDTH-2:0], q_bit};
          n_mag    <= n_mag << 1;
          if (cnt == '0) begin
            state <= StFinish;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        StFinish: begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= dz_flag;
          overflow    <= ovf_fin;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divsub_sign_13_6.sv
module tb_divsub_sign_13_6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [12:0] dividend;
  logic [5:0]  divisor;
  logic        busy;
  logic        done;
  logic [6:0]  quotient;
  logic [5:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divsub_sign_13_6 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  function automatic int qv();
    return int'($signed(quotient));
  endfunction

  function automatic int rv();
    return int'($signed(remainder));
  endfunction

  // Issue one operation and wait (bounded) for done. lat = edges from the
  // accepting edge to the done edge, -1 on timeout.
  task automatic run_div(input int n, input int d, output int lat, output int busy_cnt);
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = n[12:0];
    divisor  = d[5:0];
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (quotient !== 7'd0) begin bad++; $display("FAIL reset_q got %0d want 0", qv()); end
    total++; if (remainder !== 6'd0) begin bad++; $display("FAIL reset_r got %0d want 0", rv()); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
  endtask

  task automatic test_positive();
    int lat, bc;
    run_div(100, 7, lat, bc);
    total++; if (lat !== 14) begin bad++; $display("FAIL pos_latency got %0d want 14", lat); end
    total++; if (bc !== 14) begin bad++; $display("FAIL pos_busy_cycles got %0d want 14", bc); end
    total++; if (qv() !== 14) begin bad++; $display("FAIL pos_q got %0d want 14", qv()); end
    total++; if (rv() !== 2) begin bad++; $display("FAIL pos_r got %0d want 2", rv()); end
    total++; if (overflow !== 1'b0 || div_by_zero !== 1'b0)
      begin bad++; $display("FAIL pos_flags got ovf=%b dz=%b want 0 0", overflow, div_by_zero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pos_busy_at_done got %b want 0", busy); end
  endtask

  // Sign cases and overflow cases share one table: n, d, q, r, ovf.
  task automatic test_table();
    int tn[7] = '{-100,  100, -100, -4096, 4095, -4096, -2016};
    int td[7] = '{   7,   -7,   -7,   -32,    1,     1,   -32};
    int tq[7] = '{ -14,  -14,   14,    63,   63,   -64,    63};
    int tr[7] = '{  -2,    2,   -2,     0,    0,     0,     0};
    int to[7] = '{   0,    0,    0,     1,    1,     1,     0};
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      run_div(tn[i], td[i], lat, bc);
      total++;
      if (lat !== 14 || qv() !== tq[i] || rv() !== tr[i] || int'(overflow) !== to[i] ||
          div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL table_%0d (%0d/%0d) got lat=%0d q=%0d r=%0d ovf=%b dz=%b want lat=14 q=%0d r=%0d ovf=%0d dz=0",
                 i, tn[i], td[i], lat, qv(), rv(), overflow, div_by_zero, tq[i], tr[i], to[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_div(37, 0, lat, bc);
    total++;
    if (lat !== 1 || qv() !== 63 || rv() !== 0 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL dz_pos got lat=%0d q=%0d r=%0d dz=%b ovf=%b want 1 63 0 1 0",
               lat, qv(), rv(), div_by_zero, overflow);
    end
    run_div(-5, 0, lat, bc);
    total++;
    if (lat !== 1 || qv() !== -64 || rv() !== 0 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL dz_neg got lat=%0d q=%0d r=%0d dz=%b ovf=%b want 1 -64 0 1 0",
               lat, qv(), rv(), div_by_zero, overflow);
    end
    // Next normal result clears the zero flag.
    run_div(50, 5, lat, bc);
    total++;
    if (qv() !== 10 || rv() !== 0 || div_by_zero !== 1'b0)
      begin bad++; $display("FAIL dz_clear got q=%0d r=%0d dz=%b want 10 0 0", qv(), rv(), div_by_zero); end
  endtask

  task automatic test_ignored_start();
    int lat = 0;
    @(posedge clk); #1;
    start = 1'b1; dividend = 13'd100; divisor = 6'd7;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; dividend = 13'h1fce; divisor = 6'd3;  // -50 / 3
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if (lat !== 14 || qv() !== 14 || rv() !== 2)
      begin bad++; $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want 14 14 2", lat, qv(), rv()); end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL ignore_after got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones = 0;
    @(posedge clk); #1;
    start = 1'b1; dividend = 13'd100; divisor = 6'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 7'd0 || remainder !== 6'd0 ||
        div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs got busy=%b done=%b q=%0d r=%0d dz=%b ovf=%b want all 0",
               busy, done, qv(), rv(), div_by_zero, overflow);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got %0d dones want 0", dones); end
    run_div(-100, 7, lat, bc);
    total++;
    if (lat !== 14 || qv() !== -14 || rv() !== -2)
      begin bad++; $display("FAIL abort_restart got lat=%0d q=%0d r=%0d want 14 -14 -2", lat, qv(), rv()); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_div(100, -7, lat, bc);
    total++;
    if (qv() !== -14 || rv() !== 2)
      begin bad++; $display("FAIL b2b_first got q=%0d r=%0d want -14 2", qv(), rv()); end
    // Still in the done cycle: request the next operation right away.
    start = 1'b1; dividend = 13'h1f9c; divisor = 6'h39;  // -100 / -7
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL b2b_accept got done=%b busy=%b want 0 1", done, busy); end
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 14 || qv() !== 14 || rv() !== -2)
      begin bad++; $display("FAIL b2b_second got lat=%0d q=%0d r=%0d want 14 14 -2", lat, qv(), rv()); end
  endtask

  task automatic test_roundtrip();
    int a, b, din, n, eq, er, lat, bc;
    bit eo;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(127)) - 64;
      b = 0;
      while (b == 0) b = int'($urandom_range(63)) - 32;
      din = int'($urandom_range(63)) - 32;
      n   = a * b + din;
      eq  = n / b;
      er  = n % b;
      eo  = (eq > 63) || (eq < -64);
      if (eq > 63) eq = 63;
      if (eq < -64) eq = -64;
      run_div(n, b, lat, bc);
      total++;
      if (lat !== 14 || int'(overflow) !== int'(eo) || div_by_zero !== 1'b0 || qv() !== eq ||
          (!eo && (rv() !== er || qv() * b + rv() != n ||
                   (rv() < 0 ? -rv() : rv()) >= (b < 0 ? -b : b) ||
                   (rv() != 0 && ((rv() < 0) != (n < 0)))))) begin
        bad++;
        $display("FAIL roundtrip_%0d (%0d/%0d) got lat=%0d q=%0d r=%0d ovf=%b dz=%b want lat=14 q=%0d r=%0d ovf=%b dz=0",
                 i, n, b, lat, qv(), rv(), overflow, div_by_zero, eq, er, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_table();
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_roundtrip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
